// File: rtl/counter_monitor.sv
// Passive checker for the free-running counter: predicts its next value one cycle ahead
// and flags, counts and captures every cycle where the observed output disagrees.
module counter_monitor #(
    parameter int COUNTER_WIDTH = 16,
    parameter int ERR_WIDTH     = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_clear,
    input  logic                     i_enable,
    input  logic [COUNTER_WIDTH-1:0] i_counter,
    input  logic                     i_err_clear,
    output logic                     o_locked,
    output logic                     o_error,
    output logic                     o_sticky_error,
    output logic [ERR_WIDTH-1:0]     o_error_count,
    output logic [COUNTER_WIDTH-1:0] o_first_expected,
    output logic [COUNTER_WIDTH-1:0] o_first_observed
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_WIDTH-1:0]     ERR_ONE = {{(ERR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_WIDTH-1:0]     ERR_MAX = {ERR_WIDTH{1'b1}};

    state_t                   state;
    logic [COUNTER_WIDTH-1:0] expected;
    logic [COUNTER_WIDTH-1:0] next_expected;
    logic                     mismatch;

    // Model reloads from the observed value so one bad sample costs exactly one error.
    always_comb begin
        next_expected = i_counter;
        if (i_clear) begin
            next_expected = '0;
        end else if (i_enable) begin
            next_expected = i_counter + CNT_ONE;
        end
    end

    assign mismatch = (state == LOCKED) && (i_counter != expected);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= UNLOCKED;
            expected         <= '0;
            o_locked         <= 1'b0;
            o_error          <= 1'b0;
            o_sticky_error   <= 1'b0;
            o_error_count    <= '0;
            o_first_expected <= '0;
            o_first_observed <= '0;
        end else begin
            state    <= LOCKED;
            o_locked <= 1'b1;
            expected <= next_expected;
            o_error  <= mismatch;

            if (i_err_clear) begin
                o_sticky_error   <= 1'b0;
                o_error_count    <= '0;
                o_first_expected <= '0;
                o_first_observed <= '0;
            end

            // A mismatch coinciding with an error clear is recorded as the first one after it.
            if (mismatch) begin
                o_sticky_error <= 1'b1;
                if (i_err_clear) begin
                    o_error_count <= ERR_ONE;
                end else if (o_error_count != ERR_MAX) begin
                    o_error_count <= o_error_count + ERR_ONE;
                end
                if (!o_sticky_error || i_err_clear) begin
                    o_first_expected <= expected;
                    o_first_observed <= i_counter;
                end
            end
        end
    end

endmodule
